// File: rtl/sram_voice_arbiter_if.sv
// SRAM pin bundle between the voice arbiter (master) and the asynchronous 16-bit sample SRAM.
interface sram_voice_arbiter_if;
   logic [19:0] SRAM_ADDR;
   logic [15:0] SRAM_DQ;
   logic        CE_N;
   logic        OE_N;
   logic        WE_N;
   logic        UB_N;
   logic        LB_N;

   modport master (
      output SRAM_ADDR, CE_N, OE_N, WE_N, UB_N, LB_N,
      input  SRAM_DQ
   );

   modport slave (
      input  SRAM_ADDR, CE_N, OE_N, WE_N, UB_N, LB_N,
      output SRAM_DQ
   );
endinterface

// File: rtl/sram_voice_arbiter.sv
// Per-frame SRAM read arbiter for NUM_VOICES voices, with a mixed-sample accumulator.
// Optional feature: define MIX_SAT_EN to clamp the mix instead of wrapping it.
module sram_voice_arbiter #(
   parameter int unsigned NUM_VOICES = 4,
   parameter int unsigned READ_WAIT  = 1
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       sample_tick,
   input  logic [NUM_VOICES-1:0]      voice_req,
   input  logic [20*NUM_VOICES-1:0]   voice_addr,
   output logic [16*NUM_VOICES-1:0]   voice_data,
   output logic [NUM_VOICES-1:0]      voice_ack,
   sram_voice_arbiter_if.master       sram,
   output logic [15:0]                mix_out,
   output logic                       mix_valid,
   output logic                       overrun
);

   localparam int unsigned IdxW     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [2:0]  WaitLast = 3'((READ_WAIT == 0) ? 0 : READ_WAIT - 1);
   localparam logic signed [18:0] AccMax = 19'sd32767;
   localparam logic signed [18:0] AccMin = -19'sd32768;

   typedef enum logic [2:0] {StIdle, StSetup, StWait, StLatch, StDone} state_e;

   state_e                          state_q, state_d;
   logic [NUM_VOICES-1:0]           pend_q, pend_d, pend_clr;
   logic signed [18:0]              acc_q, acc_d;
   logic [2:0]                      cnt_q, cnt_d;
   logic [19:0]                     addr_q, addr_d;
   logic                            en_q, en_d;
   logic [NUM_VOICES-1:0][15:0]     data_q, data_d;
   logic [NUM_VOICES-1:0]           ack_q, ack_d;
   logic [15:0]                     mix_q, mix_d, mix_f;
   logic                            mix_valid_q, mix_valid_d;
   logic                            overrun_q, overrun_d;
   logic [NUM_VOICES-1:0][19:0]     addr_v;
   logic [IdxW-1:0]                 cur;

   assign addr_v = voice_addr;

   // Lowest pending voice; pend_q is stable from SETUP through LATCH.
   always_comb begin
      cur = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (pend_q[i]) cur = IdxW'(i);
      end
   end

   always_comb begin
`ifdef MIX_SAT_EN
      if (acc_q > AccMax)      mix_f = 16'h7FFF;
      else if (acc_q < AccMin) mix_f = 16'h8000;
      else                     mix_f = acc_q[15:0];
`else
      mix_f = acc_q[15:0];
`endif
   end

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      data_d      = data_q;
      ack_d       = '0;
      mix_d       = mix_q;
      mix_valid_d = 1'b0;
      overrun_d   = overrun_q | (sample_tick && (state_q != StIdle));
      pend_clr    = pend_q;
      pend_clr[cur] = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (sample_tick) begin
               pend_d  = voice_req;
               acc_d   = '0;
               state_d = (|voice_req) ? StSetup : StDone;
            end
         end
         StSetup: begin
            addr_d  = addr_v[cur];
            cnt_d   = '0;
            state_d = (READ_WAIT == 0) ? StLatch : StWait;
         end
         StWait: begin
            if (cnt_q == WaitLast) state_d = StLatch;
            else                   cnt_d   = cnt_q + 3'd1;
         end
         StLatch: begin
            data_d[cur] = sram.SRAM_DQ;
            ack_d[cur]  = 1'b1;
            acc_d       = acc_q + $signed({{3{sram.SRAM_DQ[15]}}, sram.SRAM_DQ});
            pend_d      = pend_clr;
            state_d     = (|pend_clr) ? StSetup : StDone;
         end
         StDone: begin
            mix_d       = mix_f;
            mix_valid_d = 1'b1;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Enables stay asserted across back-to-back voices, dropping only in DONE/IDLE.
      en_d = (state_d == StSetup) || (state_d == StWait) || (state_d == StLatch);
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q     <= StIdle;
         pend_q      <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         addr_q      <= '0;
         en_q        <= 1'b0;
         data_q      <= '0;
         ack_q       <= '0;
         mix_q       <= '0;
         mix_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         en_q        <= en_d;
         data_q      <= data_d;
         ack_q       <= ack_d;
         mix_q       <= mix_d;
         mix_valid_q <= mix_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign voice_data     = data_q;
   assign voice_ack      = ack_q;
   assign mix_out        = mix_q;
   assign mix_valid      = mix_valid_q;
   assign overrun        = overrun_q;
   assign sram.SRAM_ADDR = addr_q;
   assign sram.CE_N      = ~en_q;
   assign sram.OE_N      = ~en_q;
   assign sram.WE_N      = 1'b1;
   assign sram.UB_N      = 1'b0;
   assign sram.LB_N      = 1'b0;

endmodule

// File: tb/tb_sram_voice_arbiter.sv
// Directed bench for sram_voice_arbiter (NUM_VOICES=4, READ_WAIT=1) with a small SRAM lookup model.
module tb_sram_voice_arbiter;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        sample_tick;
   logic [3:0]  voice_req;
   logic [79:0] voice_addr;
   logic [63:0] voice_data;
   logic [3:0]  voice_ack;
   logic [15:0] mix_out;
   logic        mix_valid;
   logic        overrun;

   sram_voice_arbiter_if sif ();

   sram_voice_arbiter #(
      .NUM_VOICES (4),
      .READ_WAIT  (1)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .sample_tick (sample_tick),
      .voice_req   (voice_req),
      .voice_addr  (voice_addr),
      .voice_data  (voice_data),
      .voice_ack   (voice_ack),
      .sram        (sif.master),
      .mix_out     (mix_out),
      .mix_valid   (mix_valid),
      .overrun     (overrun)
   );

   always #5 Clk = ~Clk;

   logic [19:0] m_addr [4];
   logic [15:0] m_data [4];

   always_comb begin
      sif.SRAM_DQ = 16'hDEAD;
      for (int i = 0; i < 4; i++) begin
         if (sif.SRAM_ADDR == m_addr[i]) sif.SRAM_DQ = m_data[i];
      end
   end

   int cyc = 0;
   int mv_cnt, mv_cyc, ce_low;
   logic [3:0]  ack_log [$];
   logic [19:0] addr_log [$];
   int errors = 0;
   int checks = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   always @(negedge Clk) begin
      if (mix_valid) begin
         mv_cnt <= mv_cnt + 1;
         mv_cyc <= cyc;
      end
      if (voice_ack != 4'b0) begin
         ack_log.push_back(voice_ack);
         addr_log.push_back(sif.SRAM_ADDR);
      end
      if (!sif.CE_N) ce_low <= ce_low + 1;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic clear_log();
      mv_cnt = 0;
      mv_cyc = -1;
      ce_low = 0;
      ack_log.delete();
      addr_log.delete();
   endtask

   task automatic fire(output int t0);
      sample_tick = 1'b1;
      t0 = cyc;
      step(1);
      sample_tick = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      step(2);
      checks += 11;
      if (voice_data !== 64'h0) begin
         errors++; $display("FAIL reset_voice_data got=%h exp=0", voice_data);
      end
      if (voice_ack !== 4'h0) begin
         errors++; $display("FAIL reset_voice_ack got=%h exp=0", voice_ack);
      end
      if (sif.SRAM_ADDR !== 20'h0) begin
         errors++; $display("FAIL reset_sram_addr got=%h exp=0", sif.SRAM_ADDR);
      end
      if (sif.CE_N !== 1'b1) begin errors++; $display("FAIL reset_ce_n got=%b exp=1", sif.CE_N); end
      if (sif.OE_N !== 1'b1) begin errors++; $display("FAIL reset_oe_n got=%b exp=1", sif.OE_N); end
      if (sif.WE_N !== 1'b1) begin errors++; $display("FAIL reset_we_n got=%b exp=1", sif.WE_N); end
      if (sif.UB_N !== 1'b0) begin errors++; $display("FAIL reset_ub_n got=%b exp=0", sif.UB_N); end
      if (sif.LB_N !== 1'b0) begin errors++; $display("FAIL reset_lb_n got=%b exp=0", sif.LB_N); end
      if (mix_out !== 16'h0) begin errors++; $display("FAIL reset_mix_out got=%h exp=0", mix_out); end
      if (mix_valid !== 1'b0) begin
         errors++; $display("FAIL reset_mix_valid got=%b exp=0", mix_valid);
      end
      if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
      Reset = 1'b1;
      step(1);
   endtask

   task automatic test_two_voices();
      int t0;
      m_addr[0] = 20'h00010; m_data[0] = 16'h0100;
      m_addr[1] = 20'h00200; m_data[1] = 16'h0020;
      m_addr[2] = 20'h00300; m_data[2] = 16'h5555;
      m_addr[3] = 20'h04000; m_data[3] = 16'h6666;
      voice_addr = {20'h04000, 20'h00200, 20'h00300, 20'h00010};
      voice_req  = 4'b0101;
      clear_log();
      fire(t0);
      voice_req = 4'b1111;  // must not leak into the current frame
      step(11);
      checks += 9;
      if (ack_log.size() !== 2) begin
         errors++; $display("FAIL two_ack_count got=%0d exp=2", ack_log.size());
      end else begin
         if (ack_log[0] !== 4'b0001 || ack_log[1] !== 4'b0100) begin
            errors++; $display("FAIL two_ack_order got=%b,%b exp=0001,0100", ack_log[0], ack_log[1]);
         end
         if (addr_log[0] !== 20'h00010 || addr_log[1] !== 20'h00200) begin
            errors++;
            $display("FAIL two_sram_addr got=%h,%h exp=00010,00200", addr_log[0], addr_log[1]);
         end
      end
      if (mix_out !== 16'h0120) begin errors++; $display("FAIL two_mix got=%h exp=0120", mix_out); end
      if (mv_cnt !== 1) begin errors++; $display("FAIL two_mv_count got=%0d exp=1", mv_cnt); end
      if (mv_cyc !== t0 + 8) begin
         errors++; $display("FAIL two_latency got=%0d exp=%0d", mv_cyc, t0 + 8);
      end
      if (voice_data[15:0] !== 16'h0100 || voice_data[47:32] !== 16'h0020) begin
         errors++; $display("FAIL two_voice_data got=%h exp=0000002000000100", voice_data);
      end
      if (voice_data[31:16] !== 16'h0 || voice_data[63:48] !== 16'h0) begin
         errors++; $display("FAIL two_unreq_data got=%h exp=0000002000000100", voice_data);
      end
      if (ce_low !== 6) begin errors++; $display("FAIL two_ce_low_cycles got=%0d exp=6", ce_low); end
      voice_req = 4'b0000;
   endtask

   task automatic test_no_req();
      int t0;
      voice_req = 4'b0000;
      clear_log();
      fire(t0);
      step(5);
      checks += 5;
      if (ce_low !== 0) begin errors++; $display("FAIL none_ce_low got=%0d exp=0", ce_low); end
      if (mv_cnt !== 1) begin errors++; $display("FAIL none_mv_count got=%0d exp=1", mv_cnt); end
      if (mv_cyc !== t0 + 2) begin
         errors++; $display("FAIL none_latency got=%0d exp=%0d", mv_cyc, t0 + 2);
      end
      if (mix_out !== 16'h0) begin errors++; $display("FAIL none_mix got=%h exp=0", mix_out); end
      if (ack_log.size() !== 0) begin
         errors++; $display("FAIL none_ack got=%0d exp=0", ack_log.size());
      end
   endtask

   task automatic test_saturate();
      int t0;
      logic [15:0] exp_mix;
`ifdef MIX_SAT_EN
      exp_mix = 16'h7FFF;
`else
      exp_mix = 16'hE000;
`endif
      m_addr[0] = 20'h00010; m_data[0] = 16'h7000;
      m_addr[1] = 20'h00020; m_data[1] = 16'h7000;
      voice_addr = {20'h0, 20'h0, 20'h00020, 20'h00010};
      voice_req  = 4'b0011;
      clear_log();
      fire(t0);
      step(10);
      checks += 2;
      if (mix_out !== exp_mix) begin
         errors++; $display("FAIL sat_mix got=%h exp=%h", mix_out, exp_mix);
      end
      if (mv_cyc !== t0 + 8) begin
         errors++; $display("FAIL sat_latency got=%0d exp=%0d", mv_cyc, t0 + 8);
      end
   endtask

   task automatic test_overrun();
      int t0;
      m_addr[0] = 20'h00100; m_data[0] = 16'h0001;
      m_addr[1] = 20'h00200; m_data[1] = 16'h0002;
      m_addr[2] = 20'h00300; m_data[2] = 16'h0003;
      m_addr[3] = 20'h00400; m_data[3] = 16'h0004;
      voice_addr = {20'h00400, 20'h00300, 20'h00200, 20'h00100};
      voice_req  = 4'b1111;
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before got=%b exp=0", overrun); end
      clear_log();
      fire(t0);
      step(2);
      sample_tick = 1'b1;  // arrives in LATCH of voice 0
      step(1);
      sample_tick = 1'b0;
      step(16);
      checks += 5;
      if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", overrun); end
      if (mv_cnt !== 1) begin errors++; $display("FAIL ovr_mv_count got=%0d exp=1", mv_cnt); end
      if (mv_cyc !== t0 + 14) begin
         errors++; $display("FAIL ovr_latency got=%0d exp=%0d", mv_cyc, t0 + 14);
      end
      if (mix_out !== 16'h000A) begin errors++; $display("FAIL ovr_mix got=%h exp=000a", mix_out); end
      if (ack_log.size() !== 4) begin
         errors++; $display("FAIL ovr_ack_count got=%0d exp=4", ack_log.size());
      end
      step(5);
      checks++;
      if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
   endtask

   task automatic test_reset_midframe();
      int t0;
      m_addr[1] = 20'h00030; m_data[1] = 16'h1234;
      voice_addr = {20'h0, 20'h0, 20'h00030, 20'h0};
      voice_req  = 4'b0010;
      clear_log();
      fire(t0);
      step(1);
      Reset = 1'b0;  // held through the WAIT cycle of voice 1
      step(1);
      checks += 2;
      if (sif.CE_N !== 1'b1) begin errors++; $display("FAIL mid_ce_n got=%b exp=1", sif.CE_N); end
      if (sif.OE_N !== 1'b1) begin errors++; $display("FAIL mid_oe_n got=%b exp=1", sif.OE_N); end
      Reset = 1'b1;
      step(8);
      checks += 4;
      if (ack_log.size() !== 0) begin
         errors++; $display("FAIL mid_no_ack got=%0d exp=0", ack_log.size());
      end
      if (mv_cnt !== 0) begin errors++; $display("FAIL mid_no_mix got=%0d exp=0", mv_cnt); end
      if (overrun !== 1'b0) begin errors++; $display("FAIL mid_ovr_clr got=%b exp=0", overrun); end
      if (voice_data !== 64'h0) begin
         errors++; $display("FAIL mid_data_clr got=%h exp=0", voice_data);
      end
      clear_log();
      fire(t0);
      step(8);
      checks += 3;
      if (ack_log.size() !== 1 || ack_log[0] !== 4'b0010) begin
         errors++; $display("FAIL mid_rerun_ack got=%0d entries exp=1 of 0010", ack_log.size());
      end
      if (mix_out !== 16'h1234 || voice_data[31:16] !== 16'h1234) begin
         errors++; $display("FAIL mid_rerun_data got=%h/%h exp=1234", mix_out, voice_data[31:16]);
      end
      if (mv_cyc !== t0 + 5) begin
         errors++; $display("FAIL mid_rerun_latency got=%0d exp=%0d", mv_cyc, t0 + 5);
      end
   endtask

   initial begin
      Reset       = 1'b0;
      sample_tick = 1'b0;
      voice_req   = 4'b0;
      voice_addr  = 80'h0;
      for (int i = 0; i < 4; i++) begin
         m_addr[i] = 20'hFFFFF;
         m_data[i] = 16'h0;
      end
      clear_log();
      test_reset();
      test_two_voices();
      test_no_req();
      test_saturate();
      test_overrun();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
